// File: rtl/aes_pkg.sv
// AES-128 shared types, S-box and key-schedule helpers for the iterative engine.
`default_nettype none
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;
  typedef logic [1:0]   fsm_t;

  localparam int NR_AES128 = 10;

  localparam fsm_t ST_IDLE = 2'd0;
  localparam fsm_t ST_RUN  = 2'd1;
  localparam fsm_t ST_DONE = 2'd2;

  // Entry b lives at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t rcon(input logic [3:0] rnd);
    byte_t r;
    r = 8'h01;
    for (int i = 1; i < NR_AES128; i++) begin
      if (4'(i) < rnd) r = xtime(r);
    end
    return r;
  endfunction

  function automatic state_t key_step(input state_t rk, input byte_t rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
`default_nettype none
module sub_bytes
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_o[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
  end
endmodule

module shift_rows
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);
  // Byte (row r, col c) sits at index 4*c + r; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_o[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_columns
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t a0, a1, a2, a3;
    assign a0 = state_i[127-32*c -: 8];
    assign a1 = state_i[119-32*c -: 8];
    assign a2 = state_i[111-32*c -: 8];
    assign a3 = state_i[103-32*c -: 8];
    assign state_o[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end
endmodule

module aes_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t rk_i,
  input  logic   last_i,
  output state_t state_o
);
  state_t sb, sr, mc;

  sub_bytes   u_sub_bytes   (.state_i(state_i), .state_o(sb));
  shift_rows  u_shift_rows  (.state_i(sb),      .state_o(sr));
  mix_columns u_mix_columns (.state_i(sr),      .state_o(mc));

  assign state_o = (last_i ? sr : mc) ^ rk_i;
endmodule
`default_nettype wire

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
`default_nettype none
module aes128_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter bit B2B = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes128_iter_ctrl: NR must be 10 for AES-128");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_t       fsm_q, fsm_d;
  state_t     state_q, state_d, rk_q, rk_d, rk_next, round_out;
  logic [3:0] rnd_q, rnd_d;
  logic       accept, last;

  assign last    = (rnd_q == NR_L);
  assign rk_next = key_step(rk_q, rcon(rnd_q));

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_next),
    .last_i  (last),
    .state_o (round_out)
  );

  // DONE can hand off directly to the next block when the result is consumed.
  assign in_ready   = (fsm_q == ST_IDLE) || (B2B && (fsm_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (fsm_q == ST_DONE);
  assign busy       = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign ciphertext = out_valid ? state_q : '0;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    if (accept) begin
      state_d = plaintext ^ key;
      rk_d    = key;
      rnd_d   = 4'd1;
      fsm_d   = ST_RUN;
    end else begin
      case (fsm_q)
        ST_IDLE: ;
        ST_RUN: begin
          state_d = round_out;
          rk_d    = rk_next;
          if (last) fsm_d = ST_DONE;
          else      rnd_d = rnd_q + 4'd1;
        end
        ST_DONE: if (out_ready) fsm_d = ST_IDLE;
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 known-answer vectors.
`default_nettype none
`timescale 1ns/1ps
module tb_aes128_iter_ctrl;

  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int LAT = 10;  // edges from the accept edge until out_valid is seen

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;
  int           n_checks = 0;
  int           n_fail   = 0;

  aes128_iter_ctrl #(.NR(10), .B2B(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ciphertext !== 128'h0) begin n_fail++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
  endtask

  task automatic test_app_b();
    int lat;
    out_ready = 1'b0; in_valid = 1'b1; plaintext = PT_B; key = K_B;
    tick();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL appb_run: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    n_checks++; if (ciphertext !== 128'h0) begin n_fail++; $display("FAIL appb_no_leak: got %h expected 0", ciphertext); end
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL appb_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL appb_ct: got %h expected %h", ciphertext, CT_B); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL appb_done_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL appb_retire: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
  endtask

  task automatic test_app_c();
    int lat;
    out_ready = 1'b1; in_valid = 1'b1; plaintext = PT_C; key = K_C;
    tick();
    in_valid = 1'b0;
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL appc_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL appc_ct: got %h expected %h", ciphertext, CT_C); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL appc_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0; in_valid = 1'b1; plaintext = PT_B; key = K_B;
    tick();
    in_valid = 1'b0;
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
    in_valid = 1'b1; plaintext = PT_C; key = K_C;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL bp_ct[%0d]: got %h expected %h", i, ciphertext, CT_B); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_not_accepted: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1; in_valid = 1'b1; plaintext = PT_B; key = K_B;
    tick();
    plaintext = PT_C; key = K_C;
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL b2b_ct1: got %h expected %h", ciphertext, CT_B); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_done_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle: got busy=%b out_valid=%b in_ready=%b expected 1/0/0", busy, out_valid, in_ready); end
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL b2b_ct2: got %h expected %h", ciphertext, CT_C); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    out_ready = 1'b1; in_valid = 1'b1; plaintext = PT_B; key = K_B;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    n_checks++; if (out_valid !== 1'b0 || ciphertext !== 128'h0) begin n_fail++; $display("FAIL rst_mid_out: got out_valid=%b ct=%h expected 0/0", out_valid, ciphertext); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_stale_valid: got %0d cycles expected 0", seen); end
    in_valid = 1'b1; plaintext = PT_B; key = K_B;
    tick();
    in_valid = 1'b0;
    wait_ov(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rst_fresh_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL rst_fresh_ct: got %h expected %h", ciphertext, CT_B); end
    tick();
  endtask

  task automatic test_perturb();
    int lat;
    out_ready = 1'b0; in_valid = 1'b1; plaintext = PT_C; key = K_C;
    tick();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    in_valid = 1'b0;
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL perturb_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL perturb_ct: got %h expected %h", ciphertext, CT_C); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL perturb_retire: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_app_b();
    test_app_c();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_perturb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
